// File: rtl/cache_mem_arbiter.sv
// Arbitrates a shared single-port memory between the I-cache and D-cache fill logic,
// tracking outstanding reads so returned words are tagged for the owner that issued them.
module cache_mem_arbiter #(
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic        i_mem_en,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_mem_en,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic        mem_data_valid,
  output logic        i_gnt,
  output logic        d_gnt,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        i_data_valid,
  output logic        d_data_valid,
  output logic        err,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds x_req high for its whole transaction and may only
  // strobe memory while x_gnt is high; x_req low releases ownership.
  typedef enum logic [1:0] {IDLE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2, DRAIN = 2'd3} state_e;

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUT);

  state_e     state_q;
  logic       owner_q;           // 0: I-cache, 1: D-cache
  logic [2:0] cnt_q, cnt_d;
  logic       err_q;
  logic       i_gnt_q, d_gnt_q;
  logic       rd, ovf, unf;

  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      OWN_I: begin
        mem_en   = i_mem_en;
        mem_addr = i_addr;
      end
      OWN_D: begin
        mem_en    = d_mem_en;
        mem_wr    = d_wr & d_mem_en;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      default: ;
    endcase
  end

  assign rd = mem_en & ~mem_wr;

  // A read issued in the same cycle a word returns leaves the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    ovf   = 1'b0;
    unf   = 1'b0;
    if (rd && !mem_data_valid) begin
      if (cnt_q == MAX_CNT) ovf = 1'b1;
      else                  cnt_d = cnt_q + 3'd1;
    end else if (!rd && mem_data_valid) begin
      if (cnt_q == 3'd0) unf = 1'b1;
      else               cnt_d = cnt_q - 3'd1;
    end else if (rd && mem_data_valid && cnt_q == 3'd0) begin
      unf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      cnt_q   <= 3'd0;
      err_q   <= 1'b0;
      i_gnt_q <= 1'b0;
      d_gnt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (ovf || unf) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (d_req && (!i_req || !owner_q)) begin
            state_q <= OWN_D;
            owner_q <= 1'b1;
            d_gnt_q <= 1'b1;
          end else if (i_req) begin
            state_q <= OWN_I;
            owner_q <= 1'b0;
            i_gnt_q <= 1'b1;
          end
        end
        OWN_I: begin
          if (!i_req) begin
            i_gnt_q <= 1'b0;
            state_q <= (cnt_d == 3'd0) ? IDLE : DRAIN;
          end
        end
        OWN_D: begin
          if (!d_req) begin
            d_gnt_q <= 1'b0;
            state_q <= (cnt_d == 3'd0) ? IDLE : DRAIN;
          end
        end
        DRAIN: begin
          if (cnt_d == 3'd0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_gnt        = i_gnt_q;
  assign d_gnt        = d_gnt_q;
  assign i_data_valid = mem_data_valid & (cnt_q != 3'd0) & ~owner_q;
  assign d_data_valid = mem_data_valid & (cnt_q != 3'd0) & owner_q;
  assign err          = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus randomized traffic, all checked
// against a cycle-level reference model with a simple latency-4 memory.
module tb_cache_mem_arbiter;

  localparam int MAX_OUT = 4;
  localparam int LAT     = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_mem_en, d_req, d_mem_en, d_wr, mem_data_valid;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, d_gnt, mem_en, mem_wr, i_data_valid, d_data_valid, err;
  logic [15:0] mem_addr, mem_wdata;
  logic [1:0]  dbg_state;

  cache_mem_arbiter #(.MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_mem_en(i_mem_en), .i_addr(i_addr),
    .d_req(d_req), .d_mem_en(d_mem_en), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_data_valid(mem_data_valid),
    .i_gnt(i_gnt), .d_gnt(d_gnt), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid), .err(err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ret_q[$];        // cycle numbers at which the memory returns a read word
  int i_dv_seen = 0;

  // reference model: phase 0 idle, 1 owning, 2 draining; last is the owner (0 I, 1 D)
  int m_phase, m_last, m_cnt;
  bit m_err;
  bit spur, drop;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
  endtask

  task automatic clear_inputs();
    i_req = 0; i_mem_en = 0; i_addr = 0;
    d_req = 0; d_mem_en = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
    mem_data_valid = 0; spur = 0; drop = 0;
  endtask

  // Called at posedge+1; drops reset asynchronously and checks outputs at once.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_outs", {i_gnt, d_gnt, mem_en, mem_wr, mem_addr, mem_wdata,
                       i_data_valid, d_data_valid, err}, 64'd0);
    check("rst_state", dbg_state, 64'd0);
    m_phase = 0; m_last = 0; m_cnt = 0; m_err = 0;
    ret_q.delete();
    clear_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc++;
  endtask

  // One clock cycle: inputs already driven; compare at negedge, then advance model.
  task automatic tick();
    logic e_ig, e_dg, e_en, e_wr, e_idv, e_ddv;
    logic [15:0] e_a, e_w;
    bit rd;
    int nc;
    mem_data_valid = spur;
    if (ret_q.size() > 0 && ret_q[0] == cyc) begin
      void'(ret_q.pop_front());
      if (!drop) mem_data_valid = 1'b1;
    end
    e_ig = (m_phase == 1) && (m_last == 0);
    e_dg = (m_phase == 1) && (m_last == 1);
    e_en = 0; e_wr = 0; e_a = 0; e_w = 0;
    if (e_ig) begin e_en = i_mem_en; e_a = i_addr; end
    if (e_dg) begin e_en = d_mem_en; e_wr = d_wr & d_mem_en; e_a = d_addr; e_w = d_wdata; end
    e_idv = mem_data_valid && m_cnt > 0 && m_last == 0;
    e_ddv = mem_data_valid && m_cnt > 0 && m_last == 1;
    @(negedge clk);
    check("gnt", {i_gnt, d_gnt}, {e_ig, e_dg});
    check("mem_ctl", {mem_en, mem_wr}, {e_en, e_wr});
    check("mem_bus", {mem_addr, mem_wdata}, {e_a, e_w});
    check("data_valid", {i_data_valid, d_data_valid}, {e_idv, e_ddv});
    check("err", err, m_err);
    i_dv_seen += int'(i_data_valid);
    rd = e_en && !e_wr;
    if (rd) ret_q.push_back(cyc + LAT);
    if (mem_data_valid && m_cnt == 0) m_err = 1;
    if (rd && !mem_data_valid && m_cnt == MAX_OUT) m_err = 1;
    nc = m_cnt;
    if (rd && !mem_data_valid && m_cnt < MAX_OUT) nc = m_cnt + 1;
    else if (!rd && mem_data_valid && m_cnt > 0) nc = m_cnt - 1;
    case (m_phase)
      0: begin
        if (i_req && d_req) begin m_last = (m_last == 0) ? 1 : 0; m_phase = 1; end
        else if (i_req)     begin m_last = 0; m_phase = 1; end
        else if (d_req)     begin m_last = 1; m_phase = 1; end
      end
      1: if (!((m_last == 0) ? i_req : d_req)) m_phase = (nc == 0) ? 0 : 2;
      default: if (nc == 0) m_phase = 0;
    endcase
    m_cnt = nc;
    @(posedge clk); #1;
    cyc++;
  endtask

  initial begin
    rst_n = 1'b1;
    clear_inputs();
    #1;
    do_reset();

    // solo I fill: 8 reads, release, drain
    i_dv_seen = 0;
    i_req = 1;
    tick();
    check("fill_gnt", i_gnt, 64'd1);
    for (int k = 0; k < 8; k++) begin
      i_mem_en = 1; i_addr = 16'h1230 + 16'(2 * k);
      tick();
    end
    i_mem_en = 0; i_req = 0;
    tick();
    check("fill_drain", dbg_state, 64'd3);
    repeat (8) tick();
    check("fill_dv_count", i_dv_seen, 64'd8);
    check("fill_idle", dbg_state, 64'd0);
    check("fill_err", err, 64'd0);

    // tie after reset: D first, then I, then tie again goes to I
    do_reset();
    i_req = 1; d_req = 1;
    tick();
    check("tie_first_d", {i_gnt, d_gnt}, 64'b01);
    tick();
    d_req = 0;
    tick();
    check("tie_release_idle", {i_gnt, d_gnt}, 64'b00);
    d_req = 1;
    tick();
    check("tie_second_i", {i_gnt, d_gnt}, 64'b10);
    i_req = 0; d_req = 0;
    repeat (2) tick();

    // D write-through
    do_reset();
    d_req = 1; d_mem_en = 1; d_wr = 1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
    tick();
    check("wt_bus", {mem_en, mem_wr, mem_addr, mem_wdata}, {1'b1, 1'b1, 16'h0040, 16'hBEEF});
    tick();
    d_req = 0; d_mem_en = 0; d_wr = 0;
    tick();
    check("wt_no_drain", dbg_state, 64'd0);

    // overflow: 5 reads with no returns, then reset while draining
    do_reset();
    i_req = 1;
    tick();
    drop = 1;
    i_mem_en = 1;
    repeat (4) tick();
    check("ovf_pre", err, 64'd0);
    tick();
    check("ovf_err", err, 64'd1);
    i_mem_en = 0; i_req = 0;
    tick();
    check("ovf_drain", dbg_state, 64'd3);
    do_reset();

    // spurious return in IDLE
    spur = 1;
    tick();
    spur = 0;
    check("spur_err", err, 64'd1);
    tick();

    // randomized traffic, fault injection only in later segments
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      repeat (250) begin
        if ($urandom_range(15) == 0) i_req = ~i_req;
        if ($urandom_range(15) == 0) d_req = ~d_req;
        i_mem_en = 1'($urandom_range(1));
        i_addr   = 16'($urandom);
        d_mem_en = 1'($urandom_range(1));
        d_wr     = 1'($urandom_range(1));
        d_addr   = 16'($urandom);
        d_wdata  = 16'($urandom);
        spur     = (seg >= 2) && ($urandom_range(99) == 0);
        drop     = (seg >= 2) && ($urandom_range(39) == 0);
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
